// File: rtl/vec_lane_sched.sv
// Sequencer and round-robin write-back arbiter for the four vec_alu lanes.
// Each lane runs until it has returned its chunk quota; chunks drain through one write port.
module vec_lane_sched #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 64,
  parameter int REGI_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        nb_lanes,
  input  logic [CNT_W-1:0]  chunks,
  output logic              busy,
  output logic              done,
  output logic              run0,
  output logic              run1,
  output logic              run2,
  output logic              run3,
  input  logic              done0,
  input  logic              done1,
  input  logic              done2,
  input  logic              done3,
  input  logic [DATA_W-1:0] vd0,
  input  logic [DATA_W-1:0] vd1,
  input  logic [DATA_W-1:0] vd2,
  input  logic [DATA_W-1:0] vd3,
  input  logic [REGI_W-1:0] regi0,
  input  logic [REGI_W-1:0] regi1,
  input  logic [REGI_W-1:0] regi2,
  input  logic [REGI_W-1:0] regi3,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REGI_W-1:0] wb_regi,
  output logic [1:0]        wb_lane
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   rem      [4];
  logic [CNT_W-1:0]   rem_nxt  [4];
  logic [DATA_W-1:0]  buf_vd   [4];
  logic [REGI_W-1:0]  buf_regi [4];
  logic [DATA_W-1:0]  lane_vd  [4];
  logic [REGI_W-1:0]  lane_regi[4];
  logic [3:0]         lane_done;
  logic [3:0]         buf_full, full_nxt;
  logic [3:0]         run_q, run_nxt, cap;
  logic [1:0]         rr_ptr, gnt_lane, scan_idx;
  logic               gnt_found, arb_en, load, rem_zero;
  logic               busy_q, done_q, wb_valid_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic [REGI_W-1:0]  wb_regi_q;
  logic [1:0]         wb_lane_q;

  always_comb begin
    lane_vd[0]   = vd0;   lane_vd[1]   = vd1;   lane_vd[2]   = vd2;   lane_vd[3]   = vd3;
    lane_regi[0] = regi0; lane_regi[1] = regi1; lane_regi[2] = regi2; lane_regi[3] = regi3;
    lane_done    = {done3, done2, done1, done0};
  end

  always_comb begin
    rem_zero = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (rem[i] != '0) rem_zero = 1'b0;
    end

    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (chunks == '0) ? S_FIN : S_RUN;
      S_RUN:   if (rem_zero) state_nxt = S_DRAIN;
      S_DRAIN: if (buf_full == '0 && !wb_valid_q) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Round-robin scan begins at rr_ptr, which always points one past the last grant.
    arb_en    = (state == S_RUN || state == S_DRAIN) && (!wb_valid_q || wb_ready);
    gnt_found = 1'b0;
    gnt_lane  = rr_ptr;
    scan_idx  = rr_ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!gnt_found && buf_full[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_lane  = scan_idx;
      end
    end
    load = arb_en && gnt_found;

    cap      = '0;
    full_nxt = '0;
    run_nxt  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cap[i] = run_q[i] && lane_done[i];
      if (state == S_IDLE && start)
        rem_nxt[i] = (2'(i) <= nb_lanes) ? chunks : '0;
      else if (cap[i])
        rem_nxt[i] = rem[i] - CNT_W'(1);
      else
        rem_nxt[i] = rem[i];
      full_nxt[i] = cap[i] || (buf_full[i] && !(load && gnt_lane == 2'(i)));
      run_nxt[i]  = (state_nxt == S_RUN) && (rem_nxt[i] != '0) && !full_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      buf_full   <= '0;
      run_q      <= '0;
      rr_ptr     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_regi_q  <= '0;
      wb_lane_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        rem[i]      <= '0;
        buf_vd[i]   <= '0;
        buf_regi[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      run_q    <= run_nxt;
      buf_full <= full_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= (state == S_FIN);
      for (int unsigned i = 0; i < 4; i++) begin
        rem[i] <= rem_nxt[i];
        if (cap[i]) begin
          buf_vd[i]   <= lane_vd[i];
          buf_regi[i] <= lane_regi[i];
        end
      end
      if (load) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= buf_vd[gnt_lane];
        wb_regi_q  <= buf_regi[gnt_lane];
        wb_lane_q  <= gnt_lane;
        rr_ptr     <= gnt_lane + 2'd1;
      end else if (wb_valid_q && wb_ready) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign run0     = run_q[0];
  assign run1     = run_q[1];
  assign run2     = run_q[2];
  assign run3     = run_q[3];
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_regi  = wb_regi_q;
  assign wb_lane  = wb_lane_q;

endmodule

// File: tb/tb_vec_lane_sched.sv
// Directed bench for vec_lane_sched: lane responders feed a per-lane scoreboard
// that the write-back monitor checks in order.
module tb_vec_lane_sched;

  typedef struct packed {
    logic [63:0] vd;
    logic [9:0]  regi;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn, start, wb_ready;
  logic [1:0]  nb_lanes;
  logic [7:0]  chunks;
  logic        busy, done, run0, run1, run2, run3, wb_valid;
  logic [63:0] wb_data;
  logic [9:0]  wb_regi;
  logic [1:0]  wb_lane;
  logic [3:0]  dn;
  logic [63:0] vdl [4];
  logic [9:0]  rgl [4];
  logic [3:0]  run_vec;

  exp_t expq [4][$];
  int   rd [4];
  int   lane_log [$];
  int   run_rise [4];
  int   w [4];
  int   seq [4];
  int   wr_cnt = 0, done_cnt = 0;
  int   flush_req = 0, flush_ack = 0;
  int   spur_req = 0, spur_ack = 0;
  int   n_assert = 0, n_fail = 0;

  assign run_vec = {run3, run2, run1, run0};

  always #5 clk = ~clk;

  vec_lane_sched #(.CNT_W(8), .DATA_W(64), .REGI_W(10)) dut (
    .clk(clk), .resetn(resetn), .start(start), .nb_lanes(nb_lanes), .chunks(chunks),
    .busy(busy), .done(done),
    .run0(run0), .run1(run1), .run2(run2), .run3(run3),
    .done0(dn[0]), .done1(dn[1]), .done2(dn[2]), .done3(dn[3]),
    .vd0(vdl[0]), .vd1(vdl[1]), .vd2(vdl[2]), .vd3(vdl[3]),
    .regi0(rgl[0]), .regi1(rgl[1]), .regi2(rgl[2]), .regi3(rgl[3]),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_regi(wb_regi), .wb_lane(wb_lane)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] nb, input logic [7:0] ch);
    start = 1'b1; nb_lanes = nb; chunks = ch;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (!done && k < max) begin
      cyc(1);
      k++;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  task automatic chk_order(input string tag, input int base, input int n);
    chk({tag, "_count"}, 64'(lane_log.size() - base), 64'(n));
    for (int k = 0; k < n && base + k < lane_log.size(); k++)
      chk({tag, "_lane"}, 64'(lane_log[base + k]), 64'(k));
  endtask

  // Lane responders: pulse doneN on the second cycle of run, hold while run is low.
  initial begin
    dn = '0;
    for (int i = 0; i < 4; i++) begin vdl[i] = '0; rgl[i] = '0; w[i] = 0; seq[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!resetn || dn[i]) begin
          dn[i] = 1'b0;
          w[i]  = 0;
        end else if (i == 2 && spur_req != spur_ack) begin
          spur_ack = spur_req;
          dn[i]  = 1'b1;
          vdl[i] = 64'hDEAD_BEEF_DEAD_BEEF;
          rgl[i] = 10'h3FF;
        end else if (run_vec[i]) begin
          w[i]++;
          if (w[i] == 2) begin
            seq[i]++;
            dn[i]  = 1'b1;
            vdl[i] = {8'(i), 24'(seq[i]), 32'($urandom)};
            rgl[i] = {2'(i), 8'(seq[i])};
            expq[i].push_back({vdl[i], rgl[i]});
          end
        end
      end
    end
  end

  // Write-back monitor and activity counters.
  initial begin
    logic [3:0] prev_run = '0;
    int l;
    exp_t e;
    for (int i = 0; i < 4; i++) begin rd[i] = 0; run_rise[i] = 0; end
    forever begin
      @(negedge clk);
      if (flush_req != flush_ack) begin
        for (int i = 0; i < 4; i++) rd[i] = expq[i].size();
        flush_ack = flush_req;
      end
      if (resetn) begin
        for (int i = 0; i < 4; i++)
          if (run_vec[i] && !prev_run[i]) run_rise[i]++;
        prev_run = run_vec;
        if (done) done_cnt++;
        if (wb_valid && wb_ready) begin
          l = int'(wb_lane);
          chk("wb_expected", 64'(rd[l] < expq[l].size()), 64'(1));
          if (rd[l] < expq[l].size()) begin
            e = expq[l][rd[l]];
            rd[l]++;
            chk("wb_data", wb_data, e.vd);
            chk("wb_regi", 64'(wb_regi), 64'(e.regi));
          end
          wr_cnt++;
          lane_log.push_back(l);
        end
      end else begin
        prev_run = '0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wr0, dc0, lb, rr[4];
    logic [63:0] s_data;
    logic [9:0]  s_regi;
    logic [1:0]  s_lane;

    resetn = 1'b0; start = 1'b0; nb_lanes = '0; chunks = '0; wb_ready = 1'b1;
    cyc(2);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_run", 64'(run_vec), 64'(0));
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_wb_fields", 64'({wb_data[0], wb_regi, wb_lane}), 64'(0));
    resetn = 1'b1;
    cyc(1);

    // 1: all four lanes, one chunk each
    wr0 = wr_cnt; dc0 = done_cnt; lb = lane_log.size();
    do_start(2'd3, 8'd1);
    chk("t1_busy_after_start", 64'(busy), 64'(1));
    wait_done("t1_done", 60);
    chk("t1_busy_at_done", 64'(busy), 64'(0));
    chk("t1_writes_at_done", 64'(wr_cnt - wr0), 64'(4));
    cyc(1);
    chk("t1_done_one_cycle", 64'(done), 64'(0));
    chk("t1_done_count", 64'(done_cnt - dc0), 64'(1));
    chk_order("t1_order", lb, 4);

    // 2: single lane, five chunks
    wr0 = wr_cnt; for (int i = 0; i < 4; i++) rr[i] = run_rise[i];
    do_start(2'd0, 8'd5);
    wait_done("t2_done", 100);
    chk("t2_writes_at_done", 64'(wr_cnt - wr0), 64'(5));
    cyc(1);
    chk("t2_run0_pulses", 64'(run_rise[0] - rr[0]), 64'(5));
    chk("t2_run_others", 64'((run_rise[1] - rr[1]) + (run_rise[2] - rr[2]) + (run_rise[3] - rr[3])), 64'(0));

    // 3: two lanes, three chunks, write port stalled
    wr0 = wr_cnt;
    wb_ready = 1'b0;
    do_start(2'd1, 8'd3);
    cyc(8);
    chk("t3_run0_low", 64'(run0), 64'(0));
    chk("t3_run1_low", 64'(run1), 64'(0));
    chk("t3_wb_valid", 64'(wb_valid), 64'(1));
    s_data = wb_data; s_regi = wb_regi; s_lane = wb_lane;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("t3_stall_data", wb_data, s_data);
      chk("t3_stall_regi_lane", 64'({wb_regi, wb_lane}), 64'({s_regi, s_lane}));
    end
    chk("t3_no_write_stalled", 64'(wr_cnt - wr0), 64'(0));
    wb_ready = 1'b1;
    wait_done("t3_done", 100);
    cyc(1);
    chk("t3_writes", 64'(wr_cnt - wr0), 64'(6));

    // 4: zero chunks
    wr0 = wr_cnt; for (int i = 0; i < 4; i++) rr[i] = run_rise[i];
    start = 1'b1; nb_lanes = 2'd3; chunks = 8'd0;
    cyc(1);
    start = 1'b0;
    chk("t4_done_early", 64'(done), 64'(0));
    cyc(1);
    chk("t4_done_at_2", 64'(done), 64'(1));
    chk("t4_busy_at_done", 64'(busy), 64'(0));
    cyc(1);
    chk("t4_done_one_cycle", 64'(done), 64'(0));
    chk("t4_no_run", 64'((run_rise[0] - rr[0]) + (run_rise[1] - rr[1]) + (run_rise[2] - rr[2]) + (run_rise[3] - rr[3])), 64'(0));
    chk("t4_no_writes", 64'(wr_cnt - wr0), 64'(0));

    // 5: restart and spurious done2 during RUN
    wr0 = wr_cnt; dc0 = done_cnt; for (int i = 0; i < 4; i++) rr[i] = run_rise[i];
    do_start(2'd1, 8'd3);
    cyc(1);
    spur_req++;
    start = 1'b1; nb_lanes = 2'd3; chunks = 8'd7;
    cyc(1);
    start = 1'b0;
    wait_done("t5_done", 100);
    cyc(6);
    chk("t5_writes", 64'(wr_cnt - wr0), 64'(6));
    chk("t5_done_count", 64'(done_cnt - dc0), 64'(1));
    chk("t5_idle_after", 64'(busy), 64'(0));
    chk("t5_run23_never", 64'((run_rise[2] - rr[2]) + (run_rise[3] - rr[3])), 64'(0));

    // 6: reset in DRAIN with a write pending, then a clean rerun
    wb_ready = 1'b0;
    do_start(2'd3, 8'd1);
    cyc(8);
    chk("t6_pending_valid", 64'(wb_valid), 64'(1));
    chk("t6_pending_busy", 64'(busy), 64'(1));
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    chk("t6_rst_busy_done", 64'({busy, done}), 64'(0));
    chk("t6_rst_run", 64'(run_vec), 64'(0));
    chk("t6_rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("t6_rst_wb_data", wb_data, 64'(0));
    chk("t6_rst_wb_regi_lane", 64'({wb_regi, wb_lane}), 64'(0));
    flush_req++;
    wb_ready = 1'b1;
    cyc(2);
    chk("t6_stays_idle", 64'(busy), 64'(0));
    wr0 = wr_cnt; lb = lane_log.size();
    do_start(2'd3, 8'd1);
    wait_done("t6_done", 60);
    cyc(1);
    chk("t6_writes", 64'(wr_cnt - wr0), 64'(4));
    chk_order("t6_order", lb, 4);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
